sys_ctrl_gen: RTL and testbench
===============================

Name: sys_ctrl_gen

Overview:
- Parametrised command controller between the UART RX parallel output and the register file, ALU and TX FIFO.
- Decodes framed commands: register write, register read, ALU op with operands, ALU op without operands.
- Generalised in data, address and result widths. Adds bounded waits on RdData_Valid and OUT_Valid, per-byte FIFO backpressure on multi-byte results, and error signalling.

Parameters:
- DATA_W, 8, width of RX/TX bytes, register data and ALU operands.
- ADDR_W, 4, register-file address width.
- FUN_W, 4, ALU function code width (taken from the LSBs of the function byte).
- RES_W, 16, ALU result width; must be an integer multiple of DATA_W (RES_BYTES = RES_W/DATA_W).
- WAIT_MAX, 15, maximum cycles to wait for RdData_Valid or OUT_Valid before timeout.
- ERR_CODE, 8'hEE, byte returned when the optional feature is enabled.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-low reset
- RX_P_DATA  in  DATA_W  received byte
- RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
- RdData  in  DATA_W  register-file read data
- RdData_Valid  in  1  read data valid strobe
- ALU_OUT  in  RES_W  ALU result
- OUT_Valid  in  1  ALU result valid strobe
- FIFO_FULL  in  1  TX FIFO full
- Address  out  ADDR_W  register-file address
- WrEn  out  1  register write strobe
- RdEn  out  1  register read strobe
- WrData  out  DATA_W  register write data
- ALU_FUN  out  FUN_W  ALU function
- EN  out  1  ALU enable
- CLK_EN  out  1  ALU clock-gate enable
- TX_P_DATA  out  DATA_W  byte to TX FIFO
- TX_D_VLD  out  1  TX FIFO write strobe
- CMD_ERR  out  1  one-cycle error pulse

Behaviour:
- Reset (RST low, async) → state IDLE.
- Reset values: all outputs 0, byte counter 0, wait counter 0, result register 0.
- Reset mid-command aborts the command with no further strobes.
- Command bytes in IDLE: AA = write, BB = read, CC = ALU with operands, DD = ALU without operands.
  - Any other byte with RX_D_VLD: stay IDLE, pulse CMD_ERR next cycle.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, FUN, ALU_WAIT, TX_SEND.
- Transitions and actions:
  - WR_ADDR: on RX_D_VLD, latch RX_P_DATA[ADDR_W-1:0] into addr_reg → WR_DATA.
  - WR_DATA: on RX_D_VLD, WrEn=1 and WrData=RX_P_DATA for exactly the next cycle (registered) → IDLE.
  - RD_ADDR: on RX_D_VLD, latch address, RdEn=1 for the next cycle → RD_WAIT.
  - RD_WAIT: on RdData_Valid, result[DATA_W-1:0]=RdData, nbytes=1 → TX_SEND.
  - OP_A / OP_B: on RX_D_VLD, one-cycle WrEn to address 0 / 1 with WrData=RX_P_DATA → next state.
    - OP_A → OP_B; OP_B → FUN.
  - DD skips OP_A/OP_B and enters FUN directly.
  - FUN: on RX_D_VLD, ALU_FUN latched from RX_P_DATA[FUN_W-1:0] → ALU_WAIT.
  - ALU_WAIT: EN=1 and CLK_EN=1 throughout, ALU_FUN held. On OUT_Valid, capture ALU_OUT, nbytes=RES_BYTES → TX_SEND.
  - TX_SEND:
    - TX_D_VLD = !FIFO_FULL (combinational); TX_P_DATA = result byte[cnt], LSB byte first.
    - cnt increments only on cycles with TX_D_VLD=1.
    - After byte nbytes-1 is sent → IDLE, cnt cleared.
- Address is driven from addr_reg continuously; it is 0/1 during operand writes.
- WrEn/RdEn never assert in the same cycle.
- Timeout: the wait counter clears on entry to RD_WAIT / ALU_WAIT.
  - If the counter reaches WAIT_MAX without the valid strobe: pulse CMD_ERR, drop EN/CLK_EN, → IDLE.
  - A valid strobe arriving in the same cycle as expiry wins (no error).
- RX_D_VLD in RD_WAIT, ALU_WAIT or TX_SEND: byte ignored, CMD_ERR pulsed, state unaffected.
- FIFO_FULL held high stalls TX_SEND indefinitely (no timeout); the result register is stable meanwhile.

Optional Feature:
- Macro: SYS_CTRL_ERR_RESP_EN.
- Defined:
  - Every CMD_ERR event (bad opcode, timeout, busy drop) also queues ERR_CODE as a single TX byte.
  - The byte goes out via TX_SEND from IDLE/timeout paths.
  - A busy drop sets a pending flag; the error byte is sent after the current TX_SEND completes.
  - At most one pending error byte is held.
- Undefined: CMD_ERR pulse only; nothing is sent to TX.

Test Plan:
- RX AA,05,3C → one-cycle WrEn with Address=5, WrData=3C, the cycle after the third byte; no TX activity.
- RX BB,07; RdData=A5 valid 2 cycles after RdEn → single TX byte A5, TX_D_VLD high for 1 cycle.
- RX CC,10,20,00 with ALU_OUT=0030 at OUT_Valid → operand writes at addresses 0/1, then TX bytes 30 then 00, EN/CLK_EN high until OUT_Valid.
- DD,02 with FIFO_FULL high 5 cycles during TX_SEND → no TX_D_VLD while full; both result bytes sent in order after release, no byte lost or repeated.
- RX BB,03 with no RdData_Valid → CMD_ERR after WAIT_MAX cycles, returns to IDLE; next AA command executes normally. With SYS_CTRL_ERR_RESP_EN, TX byte EE is sent.
- Opcode 55 in IDLE, and RST asserted mid ALU_WAIT → CMD_ERR pulse for the opcode; after reset all outputs 0, state IDLE.

Source files
------------

// File: rtl/sys_ctrl_gen.sv
// Command controller: decodes framed UART commands into register-file writes/reads and ALU
// operations, then streams results to the TX FIFO. Optional error-byte response: SYS_CTRL_ERR_RESP_EN.
module sys_ctrl_gen #(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 4,
  parameter int                 FUN_W    = 4,
  parameter int                 RES_W    = 16,
  parameter int                 WAIT_MAX = 15,
  parameter logic [DATA_W-1:0]  ERR_CODE = 8'hEE
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] RX_P_DATA,
  input  logic              RX_D_VLD,
  input  logic [DATA_W-1:0] RdData,
  input  logic              RdData_Valid,
  input  logic [RES_W-1:0]  ALU_OUT,
  input  logic              OUT_Valid,
  input  logic              FIFO_FULL,
  output logic [ADDR_W-1:0] Address,
  output logic              WrEn,
  output logic              RdEn,
  output logic [DATA_W-1:0] WrData,
  output logic [FUN_W-1:0]  ALU_FUN,
  output logic              EN,
  output logic              CLK_EN,
  output logic [DATA_W-1:0] TX_P_DATA,
  output logic              TX_D_VLD,
  output logic              CMD_ERR
);

  localparam int RES_BYTES = RES_W / DATA_W;
  localparam int CNT_W     = $clog2(RES_BYTES + 1);
  localparam int WCNT_W    = $clog2(WAIT_MAX + 1);

  localparam logic [DATA_W-1:0] OPC_WR  = DATA_W'(8'hAA);
  localparam logic [DATA_W-1:0] OPC_RD  = DATA_W'(8'hBB);
  localparam logic [DATA_W-1:0] OPC_ALU = DATA_W'(8'hCC);
  localparam logic [DATA_W-1:0] OPC_FUN = DATA_W'(8'hDD);

`ifdef SYS_CTRL_ERR_RESP_EN
  localparam logic ERR_RESP = 1'b1;
`else
  localparam logic ERR_RESP = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_ADDR  = 4'd1,
    WR_DATA  = 4'd2,
    RD_ADDR  = 4'd3,
    RD_WAIT  = 4'd4,
    OP_A     = 4'd5,
    OP_B     = 4'd6,
    FUN      = 4'd7,
    ALU_WAIT = 4'd8,
    TX_SEND  = 4'd9
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wrdata_q, wrdata_d;
  logic [FUN_W-1:0]    alu_fun_q, alu_fun_d;
  logic                wren_q, wren_d;
  logic                rden_q, rden_d;
  logic                en_q, en_d;
  logic                cmd_err_q, cmd_err_d;
  logic [RES_W-1:0]    result_q, result_d;
  logic [CNT_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                pend_q, pend_d;
  logic                err_tx_s;
  logic                busy_s;
  logic [DATA_W-1:0]   tx_byte_s;

  // Result byte selected by the send counter, LSB byte first
  always_comb begin
    tx_byte_s = '0;
    for (int i = 0; i < RES_BYTES; i++) begin
      tx_byte_s = (cnt_q == CNT_W'(i)) ? result_q[i*DATA_W +: DATA_W] : tx_byte_s;
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wrdata_d  = wrdata_q;
    alu_fun_d = alu_fun_q;
    en_d      = en_q;
    result_d  = result_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    wcnt_d    = wcnt_q;
    pend_d    = pend_q;
    wren_d    = 1'b0;
    rden_d    = 1'b0;
    cmd_err_d = 1'b0;
    err_tx_s  = 1'b0;
    busy_s    = (state_q == RD_WAIT) || (state_q == ALU_WAIT) || (state_q == TX_SEND);

    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          case (RX_P_DATA)
            OPC_WR:  state_d = WR_ADDR;
            OPC_RD:  state_d = RD_ADDR;
            OPC_ALU: state_d = OP_A;
            OPC_FUN: state_d = FUN;
            default: begin
              cmd_err_d = 1'b1;
              err_tx_s  = 1'b1;
            end
          endcase
        end else if (pend_q) begin
          err_tx_s = 1'b1;
          pend_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_W-1:0];
          state_d = WR_DATA;
        end else begin
          state_d = WR_ADDR;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wren_d   = 1'b1;
          wrdata_d = RX_P_DATA;
          state_d  = IDLE;
        end else begin
          state_d = WR_DATA;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_W-1:0];
          rden_d  = 1'b1;
          wcnt_d  = '0;
          state_d = RD_WAIT;
        end else begin
          state_d = RD_ADDR;
        end
      end
      RD_WAIT: begin
        // A strobe on the expiry cycle still completes the read
        if (RdData_Valid) begin
          result_d = RES_W'(RdData);
          last_d   = '0;
          cnt_d    = '0;
          state_d  = TX_SEND;
        end else if (wcnt_q == WCNT_W'(WAIT_MAX)) begin
          cmd_err_d = 1'b1;
          err_tx_s  = 1'b1;
          state_d   = IDLE;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      OP_A: begin
        if (RX_D_VLD) begin
          addr_d   = '0;
          wren_d   = 1'b1;
          wrdata_d = RX_P_DATA;
          state_d  = OP_B;
        end else begin
          state_d = OP_A;
        end
      end
      OP_B: begin
        if (RX_D_VLD) begin
          addr_d   = ADDR_W'(1);
          wren_d   = 1'b1;
          wrdata_d = RX_P_DATA;
          state_d  = FUN;
        end else begin
          state_d = OP_B;
        end
      end
      FUN: begin
        if (RX_D_VLD) begin
          alu_fun_d = RX_P_DATA[FUN_W-1:0];
          en_d      = 1'b1;
          wcnt_d    = '0;
          state_d   = ALU_WAIT;
        end else begin
          state_d = FUN;
        end
      end
      ALU_WAIT: begin
        if (OUT_Valid) begin
          result_d = ALU_OUT;
          last_d   = CNT_W'(RES_BYTES - 1);
          cnt_d    = '0;
          en_d     = 1'b0;
          state_d  = TX_SEND;
        end else if (wcnt_q == WCNT_W'(WAIT_MAX)) begin
          cmd_err_d = 1'b1;
          err_tx_s  = 1'b1;
          en_d      = 1'b0;
          state_d   = IDLE;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      TX_SEND: begin
        // FIFO_FULL stalls without timing out; result_q is untouched here
        if (!FIFO_FULL) begin
          if (cnt_q == last_q) begin
            cnt_d   = '0;
            state_d = IDLE;
            if (pend_q) begin
              err_tx_s = 1'b1;
              pend_d   = 1'b0;
            end else begin
              pend_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = TX_SEND;
        end
      end
      default: state_d = IDLE;
    endcase

    if (busy_s && RX_D_VLD) begin
      cmd_err_d = 1'b1;
      pend_d    = ERR_RESP;
    end else begin
      busy_s = busy_s;
    end

    if (ERR_RESP && err_tx_s) begin
      result_d = RES_W'(ERR_CODE);
      last_d   = '0;
      cnt_d    = '0;
      state_d  = TX_SEND;
    end else begin
      err_tx_s = err_tx_s;
    end
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wrdata_q  <= '0;
      alu_fun_q <= '0;
      wren_q    <= 1'b0;
      rden_q    <= 1'b0;
      en_q      <= 1'b0;
      cmd_err_q <= 1'b0;
      result_q  <= '0;
      last_q    <= '0;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wrdata_q  <= wrdata_d;
      alu_fun_q <= alu_fun_d;
      wren_q    <= wren_d;
      rden_q    <= rden_d;
      en_q      <= en_d;
      cmd_err_q <= cmd_err_d;
      result_q  <= result_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      wcnt_q    <= wcnt_d;
      pend_q    <= pend_d;
    end
  end

  assign Address   = addr_q;
  assign WrEn      = wren_q;
  assign RdEn      = rden_q;
  assign WrData    = wrdata_q;
  assign ALU_FUN   = alu_fun_q;
  assign EN        = en_q;
  assign CLK_EN    = en_q;
  assign CMD_ERR   = cmd_err_q;
  assign TX_D_VLD  = (state_q == TX_SEND) && !FIFO_FULL;
  assign TX_P_DATA = tx_byte_s;

endmodule

// File: tb/tb_sys_ctrl_gen.sv
// Bench for sys_ctrl_gen: randomized command traffic, observed strobes logged with cycle
// stamps and compared against timings/values derived from the command rules.
module tb_sys_ctrl_gen;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 4;
  localparam int FUN_W    = 4;
  localparam int RES_W    = 16;
  localparam int WAIT_MAX = 15;

  logic              CLK = 1'b0;
  logic              RST;
  logic [DATA_W-1:0] RX_P_DATA;
  logic              RX_D_VLD;
  logic [DATA_W-1:0] RdData;
  logic              RdData_Valid;
  logic [RES_W-1:0]  ALU_OUT;
  logic              OUT_Valid;
  logic              FIFO_FULL;
  logic [ADDR_W-1:0] Address;
  logic              WrEn;
  logic              RdEn;
  logic [DATA_W-1:0] WrData;
  logic [FUN_W-1:0]  ALU_FUN;
  logic              EN;
  logic              CLK_EN;
  logic [DATA_W-1:0] TX_P_DATA;
  logic              TX_D_VLD;
  logic              CMD_ERR;

  sys_ctrl_gen #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FUN_W(FUN_W), .RES_W(RES_W), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid),
    .FIFO_FULL(FIFO_FULL), .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
    .ALU_FUN(ALU_FUN), .EN(EN), .CLK_EN(CLK_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {int cyc; int a; int d;} ev_t;

  ev_t  wr_q[$];
  ev_t  rd_q[$];
  ev_t  tx_q[$];
  int   err_q[$];
  int   cycle, n_checks, n_fail, viol;
  int   rd_delay, alu_delay, rd_due, alu_due, ff_lo, ff_hi, ff_off, ff_len;
  int   en_first, en_cnt, fun_seen, rx_cyc;
  logic en_prev;
  logic [DATA_W-1:0] rd_val;
  logic [RES_W-1:0]  alu_val;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({Address, WrEn, RdEn, WrData, ALU_FUN, EN, CLK_EN, TX_P_DATA, TX_D_VLD, CMD_ERR});
  endfunction

  task automatic clear();
    wr_q.delete(); rd_q.delete(); tx_q.delete(); err_q.delete();
    rd_delay = 0; alu_delay = 0; rd_due = -100; alu_due = -100;
    ff_lo = 0; ff_hi = 0; ff_off = 0; ff_len = 0;
    en_first = -1; en_cnt = 0; fun_seen = -1;
  endtask

  // One clock cycle: drive responders, sample and log, advance past the edge
  task automatic cyc();
    cycle++;
    RdData_Valid = (cycle == rd_due);
    RdData       = rd_val;
    OUT_Valid    = (cycle == alu_due);
    ALU_OUT      = alu_val;
    FIFO_FULL    = (cycle >= ff_lo) && (cycle < ff_hi);
    #1;
    if (WrEn) wr_q.push_back('{cycle, int'(Address), int'(WrData)});
    if (RdEn) begin
      rd_q.push_back('{cycle, int'(Address), 0});
      if (rd_delay > 0) rd_due = cycle + rd_delay;
    end
    if (TX_D_VLD) tx_q.push_back('{cycle, 0, int'(TX_P_DATA)});
    if (CMD_ERR) err_q.push_back(cycle);
    if (EN) begin
      if (!en_prev) begin
        en_first = cycle;
        if (alu_delay > 0) begin
          alu_due = cycle + alu_delay;
          ff_lo   = alu_due + 1 + ff_off;
          ff_hi   = ff_lo + ff_len;
        end
      end
      en_cnt++;
      fun_seen = int'(ALU_FUN);
    end
    en_prev = EN;
    if ((WrEn && RdEn) || (CLK_EN !== EN) || (TX_D_VLD && FIFO_FULL)) viol++;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic send(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    rx_cyc    = cycle + 1;
    cyc();
    RX_D_VLD  = 1'b0;
    RX_P_DATA = 8'($urandom);
    idle($urandom_range(0, 2));
  endtask

  initial begin
    logic [7:0] a, b, d, f;
    int c, ca, cb, dl, lo, hi, k;
    int exp_c[2];

    RST = 1'b0; RX_P_DATA = '0; RX_D_VLD = 1'b0; RdData = '0; RdData_Valid = 1'b0;
    ALU_OUT = '0; OUT_Valid = 1'b0; FIFO_FULL = 1'b0;
    cycle = 0; n_checks = 0; n_fail = 0; viol = 0; en_prev = 1'b0;
    rd_val = '0; alu_val = '0;
    clear();
    repeat (2) @(posedge CLK);
    #1;
    check("reset_outputs", outs(), 64'd0);
    RST = 1'b1;
    cyc();
    check("idle_outputs", outs(), 64'd0);

    // Register writes
    for (int i = 0; i < 3; i++) begin
      a = (i == 0) ? 8'h05 : 8'($urandom);
      d = (i == 0) ? 8'h3C : 8'($urandom);
      clear();
      send(8'hAA); send(a); send(d); c = rx_cyc;
      idle(4);
      check("wr_count", wr_q.size(), 1);
      if (wr_q.size() > 0) begin
        check("wr_cycle", wr_q[0].cyc, c + 1);
        check("wr_addr", wr_q[0].a, int'(a[3:0]));
        check("wr_data", wr_q[0].d, int'(d));
      end
      check("wr_quiet", tx_q.size() + err_q.size() + rd_q.size(), 0);
    end

    // Register reads, including a response on the last allowed cycle
    for (int i = 0; i < 3; i++) begin
      dl = (i == 0) ? 2 : (i == 1) ? WAIT_MAX : $urandom_range(1, WAIT_MAX - 1);
      a  = (i == 0) ? 8'h07 : 8'($urandom);
      clear();
      rd_delay = dl;
      rd_val   = (i == 0) ? 8'hA5 : 8'($urandom);
      send(8'hBB); send(a); c = rx_cyc;
      idle(WAIT_MAX + 6);
      check("rd_count", rd_q.size(), 1);
      if (rd_q.size() > 0) begin
        check("rd_cycle", rd_q[0].cyc, c + 1);
        check("rd_addr", rd_q[0].a, int'(a[3:0]));
      end
      check("rd_tx_count", tx_q.size(), 1);
      if (tx_q.size() > 0) begin
        check("rd_tx_data", tx_q[0].d, int'(rd_val));
        check("rd_tx_cycle", tx_q[0].cyc, c + 2 + dl);
      end
      check("rd_no_err", err_q.size() + wr_q.size(), 0);
    end

    // ALU with operands
    for (int i = 0; i < 3; i++) begin
      a = (i == 0) ? 8'h10 : 8'($urandom);
      b = (i == 0) ? 8'h20 : 8'($urandom);
      f = (i == 0) ? 8'h00 : 8'($urandom);
      clear();
      alu_delay = $urandom_range(1, WAIT_MAX);
      alu_val   = (i == 0) ? 16'h0030 : 16'($urandom);
      send(8'hCC); send(a); ca = rx_cyc; send(b); cb = rx_cyc; send(f); c = rx_cyc;
      idle(WAIT_MAX + 8);
      check("alu_wr_count", wr_q.size(), 2);
      if (wr_q.size() > 1) begin
        check("opa_cycle", wr_q[0].cyc, ca + 1);
        check("opa_addr", wr_q[0].a, 0);
        check("opa_data", wr_q[0].d, int'(a));
        check("opb_cycle", wr_q[1].cyc, cb + 1);
        check("opb_addr", wr_q[1].a, 1);
        check("opb_data", wr_q[1].d, int'(b));
      end
      check("en_first", en_first, c + 1);
      check("en_cycles", en_cnt, alu_delay + 1);
      check("alu_fun", fun_seen, int'(f[3:0]));
      check("alu_tx_count", tx_q.size(), 2);
      if (tx_q.size() > 1) begin
        check("alu_tx_lo", tx_q[0].d, int'(alu_val[7:0]));
        check("alu_tx_hi", tx_q[1].d, int'(alu_val[15:8]));
        check("alu_tx_cyc0", tx_q[0].cyc, c + 2 + alu_delay);
        check("alu_tx_cyc1", tx_q[1].cyc, c + 3 + alu_delay);
      end
    end

    // ALU without operands, TX stalled by FIFO_FULL windows
    for (int i = 0; i < 3; i++) begin
      f = 8'h02;
      clear();
      alu_delay = $urandom_range(1, WAIT_MAX);
      alu_val   = 16'($urandom);
      ff_off    = (i == 0) ? 0 : (i == 1) ? 1 : $urandom_range(0, 1);
      ff_len    = (i == 0) ? 5 : (i == 1) ? 3 : $urandom_range(1, 6);
      send(8'hDD); send(f); c = rx_cyc;
      idle(WAIT_MAX + 16);
      lo = c + 2 + alu_delay + ff_off;
      hi = lo + ff_len;
      k  = 0;
      for (int t = c + 2 + alu_delay; k < 2; t++) begin
        if (t < lo || t >= hi) begin
          exp_c[k] = t;
          k++;
        end
      end
      check("ff_wr_none", wr_q.size(), 0);
      check("ff_tx_count", tx_q.size(), 2);
      if (tx_q.size() > 1) begin
        check("ff_tx_lo", tx_q[0].d, int'(alu_val[7:0]));
        check("ff_tx_hi", tx_q[1].d, int'(alu_val[15:8]));
        check("ff_tx_cyc0", tx_q[0].cyc, exp_c[0]);
        check("ff_tx_cyc1", tx_q[1].cyc, exp_c[1]);
      end
    end

    // Read timeout, then a normal write
    clear();
    send(8'hBB); send(8'h03); c = rx_cyc;
    idle(WAIT_MAX + 6);
    check("rto_err_count", err_q.size(), 1);
    if (err_q.size() > 0) check("rto_err_cycle", err_q[0], c + 2 + WAIT_MAX);
    check("rto_no_tx", tx_q.size(), 0);
    clear();
    a = 8'($urandom); d = 8'($urandom);
    send(8'hAA); send(a); send(d); c = rx_cyc;
    idle(3);
    check("post_rto_wr", wr_q.size(), 1);
    if (wr_q.size() > 0) check("post_rto_wr_ev", {wr_q[0].cyc, wr_q[0].a, wr_q[0].d},
                               {c + 1, int'(a[3:0]), int'(d)});

    // ALU timeout
    clear();
    send(8'hDD); send(8'h05); c = rx_cyc;
    idle(WAIT_MAX + 6);
    check("ato_err_count", err_q.size(), 1);
    if (err_q.size() > 0) check("ato_err_cycle", err_q[0], c + 2 + WAIT_MAX);
    check("ato_en_cycles", en_cnt, WAIT_MAX + 1);
    check("ato_no_tx", tx_q.size(), 0);

    // Bad opcodes
    for (int i = 0; i < 3; i++) begin
      b = (i == 0) ? 8'h55 : 8'($urandom);
      while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) b = 8'($urandom);
      clear();
      send(b); c = rx_cyc;
      idle(3);
      check("bad_err_count", err_q.size(), 1);
      if (err_q.size() > 0) check("bad_err_cycle", err_q[0], c + 1);
      check("bad_quiet", tx_q.size() + wr_q.size() + rd_q.size(), 0);
    end

    // Byte arriving while a read is outstanding
    clear();
    rd_delay = 6; rd_val = 8'($urandom);
    send(8'hBB); send(8'h09); c = rx_cyc;
    send(8'h77); ca = rx_cyc;
    idle(WAIT_MAX + 4);
    check("busy_err_count", err_q.size(), 1);
    if (err_q.size() > 0) check("busy_err_cycle", err_q[0], ca + 1);
    check("busy_tx_count", tx_q.size(), 1);
    if (tx_q.size() > 0) check("busy_tx_ev", {tx_q[0].cyc, tx_q[0].d}, {c + 8, int'(rd_val)});

    // Reset while waiting on the ALU
    clear();
    send(8'hCC); send(8'h11); send(8'h22); send(8'h03);
    idle(3);
    check("pre_rst_en", EN, 1'b1);
    #2 RST = 1'b0;
    #1 check("mid_rst_outputs", outs(), 64'd0);
    @(posedge CLK);
    #1 RST = 1'b1;
    clear();
    idle(WAIT_MAX + 4);
    check("post_rst_quiet", wr_q.size() + rd_q.size() + tx_q.size() + err_q.size() + en_cnt, 0);
    check("post_rst_outputs", outs(), 64'd0);

    check("protocol_violations", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
